fft_reorder: RTL
================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter: width, 16, bit width of each real/imaginary sample component.
REQ-002 Parameter: N, 9, log2 of FFT frame length (frame = 2^N samples).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: areset  input  1  reset, asynchronous, active-low.
REQ-005 Port: en_in  input  1  input sample valid; high for every sample of a frame.
REQ-006 Port: cnt_in  input  N  bit-reversed-order sample index of the current input sample.
REQ-007 Port: xin_re / xin_im  input  width each  signed input sample (FFT output, bit-reversed order).
REQ-008 Port: en_out  output  1  output sample valid.
REQ-009 Port: cnt_out  output  N  natural-order index of the current output sample.
REQ-010 Port: yout_re / yout_im  output  width each  signed output sample, natural order.
REQ-011 Port: ovf  output  1  sticky overflow flag.

Function
REQ-012 The block SHALL convert each 2^N-sample frame from bit-reversed order to natural order, using ping-pong double buffering (banks 0 and 1).
REQ-013 Write: on each edge with en_in=1, the sample SHALL be stored in bank wr_bank at address bitrev(cnt_in); en_in=0 writes nothing.
REQ-014 Frame completion: an edge with en_in=1 and cnt_in=2^N-1 SHALL set full[wr_bank] and toggle wr_bank at that edge.
REQ-015 Read FSM states: IDLE, READ; in IDLE, full[rd_bank]=1 SHALL move to READ at the next edge with rd_addr=0.
REQ-016 In READ, rd_addr SHALL increment by 1 each cycle from 0 to 2^N-1 with no stalls.
REQ-017 On the edge where rd_addr=2^N-1 in READ: clear full[rd_bank], toggle rd_bank, rd_addr wraps to 0; stay in READ if full of the other bank is set (including being set on that same edge), else go to IDLE.
REQ-018 RAM read is registered: data for rd_addr SHALL appear on yout_re/yout_im one cycle after the address is issued, with en_out=1 and cnt_out=rd_addr of that address aligned to it.
REQ-019 Latency: first en_out=1 of a frame SHALL occur 2 clock edges after the edge capturing the last input sample (cnt_in=2^N-1) when the FSM is IDLE.
REQ-020 Back-to-back input frames SHALL produce contiguous en_out for 2^N cycles per frame with no gap; cnt_out SHALL run 0..2^N-1 and wrap.
REQ-021 When en_out=0, yout_re/yout_im/cnt_out SHALL hold their last values.
REQ-022 Simultaneous set of full[x] by the writer and clear of full[y] by the reader SHALL both take effect.
REQ-023 An en_in=1 write into a bank whose full flag is set SHALL set ovf=1 (sticky until reset); the write still proceeds.
REQ-024 A frame whose en_in drops before cnt_in=2^N-1 is not completed; subsequent writes continue into the same wr_bank.
REQ-025 No arithmetic on samples: data SHALL pass bit-exact from input to output.

Reset
REQ-026 areset low SHALL immediately force en_out=0, cnt_out=0, yout_re=0, yout_im=0, ovf=0, full[1:0]=0, wr_bank=0, rd_bank=0, rd_addr=0, FSM=IDLE.
REQ-027 Reset mid-frame SHALL discard partial and pending frames; RAM contents are not reset and are never output without a new completed frame.

Structure
REQ-028 Default parameters (width, N) and the bitrev function SHALL live in the shared include fft_defs.vh used by all FFT stages.
REQ-029 Storage SHALL be one sub-module reorder_ram: simple dual-port, depth 2^(N+1) addressed {bank, addr}, data 2*width, synchronous write, registered read.
REQ-030 Control (write addressing, full flags, read FSM, output registers) SHALL reside in fft_reorder.

Verification (bench uses N=3, width=16)
REQ-031 One frame, cnt_in=0..7, xin_re=cnt_in, xin_im=-cnt_in -> en_out high 8 cycles, 2 edges after last input; cnt_out 0..7; yout_re 0,4,2,6,1,5,3,7; yout_im negated.
REQ-032 Three back-to-back frames (re offset 0, 8, 16) -> 24 contiguous en_out cycles, each frame reordered correctly, ovf=0.
REQ-033 Two frames separated by 5 idle cycles -> two 8-cycle en_out bursts separated by 5 low cycles, data correct.
REQ-034 Assert areset low after input sample cnt_in=5, then send a full frame -> no output from the partial frame; the new frame is output correctly.
REQ-035 Force write into a full bank (stall-free overlap by injecting a third frame while two are pending via a held second frame) -> ovf=1 and held until reset.
REQ-036 en_in dropped after cnt_in=3 for 4 cycles then resumed at cnt_in=4..7 -> frame completes normally, output identical to REQ-031.

Source files
------------

// File: rtl/fft_reorder_pkg.sv
// rtl/fft_reorder_pkg.sv - shared types and FFT defaults for the reorder stage
package fft_reorder_pkg;

  `include "fft_defs.vh"

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fft_defs.vh
// rtl/fft_defs.vh - shared FFT default parameters and bit-reversal helper
`ifndef FFT_DEFS_VH
`define FFT_DEFS_VH

localparam int FFT_WIDTH = 16;
localparam int FFT_N     = 9;
localparam int FFT_MAX_N = 16;

function automatic logic [FFT_MAX_N-1:0] bitrev_full(input logic [FFT_MAX_N-1:0] v);
  logic [FFT_MAX_N-1:0] r;
  for (int i = 0; i < FFT_MAX_N; i++) begin
    r[i] = v[FFT_MAX_N-1-i];
  end
  return r;
endfunction

// Reverse the low n bits of v; v must be zero above bit n-1.
function automatic logic [FFT_MAX_N-1:0] bitrev(input logic [FFT_MAX_N-1:0] v, input int n);
  return bitrev_full(v) >> (FFT_MAX_N - n);
endfunction

`endif

// File: rtl/fft_reorder_ram.sv
// rtl/fft_reorder_ram.sv - simple dual-port sample store, synchronous write, registered read
module reorder_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register doubles as the output sample register, so it holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong bit-reversed to natural order frame reorder
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int width = FFT_WIDTH,
  parameter int N     = FFT_N
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    en_in,
  input  logic [N-1:0]            cnt_in,
  input  logic signed [width-1:0] xin_re,
  input  logic signed [width-1:0] xin_im,
  output logic                    en_out,
  output logic [N-1:0]            cnt_out,
  output logic signed [width-1:0] yout_re,
  output logic signed [width-1:0] yout_im,
  output logic                    ovf
);

  localparam logic [N-1:0] LAST = '1;

  rd_state_e        state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [N-1:0]     rd_addr_q, rd_addr_d;
  logic             ovf_q, ovf_d;
  logic             en_out_q;
  logic [N-1:0]     cnt_out_q;

  logic             frame_done;
  logic             read_done;
  logic             rd_en;
  logic [N-1:0]     wr_addr;
  logic [2*width-1:0] rd_data;

  assign wr_addr    = N'(bitrev(FFT_MAX_N'(cnt_in), N));
  assign frame_done = en_in && (cnt_in == LAST);
  assign rd_en      = (state_q == RD_READ);
  assign read_done  = rd_en && (rd_addr_q == LAST);

  // A completed frame wins over a same-edge clear so it is never lost.
  always_comb begin
    full_d    = full_q;
    ovf_d     = ovf_q;
    wr_bank_d = wr_bank_q;
    if (read_done) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    // Writing into the bank whose last word is read on this edge is not an overrun.
    if (en_in && full_q[wr_bank_q] && !(read_done && (rd_bank_q == wr_bank_q))) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = RD_READ;
          rd_addr_d = '0;
        end
      end
      RD_READ: begin
        rd_addr_d = rd_addr_q + 1'b1;
        if (read_done) begin
          rd_bank_d = ~rd_bank_q;
          rd_addr_d = '0;
          if (!full_d[~rd_bank_q]) begin
            state_d = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= RD_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      rd_addr_q <= '0;
      ovf_q     <= 1'b0;
      en_out_q  <= 1'b0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      rd_addr_q <= rd_addr_d;
      ovf_q     <= ovf_d;
      en_out_q  <= rd_en;
      if (rd_en) begin
        cnt_out_q <= rd_addr_q;
      end
    end
  end

  reorder_ram #(
    .DW(2*width),
    .AW(N+1)
  ) u_ram (
    .clk       (clk),
    .rst_n     (areset),
    .wr_en_i   (en_in),
    .wr_addr_i ({wr_bank_q, wr_addr}),
    .wr_data_i ({xin_re, xin_im}),
    .rd_en_i   (rd_en),
    .rd_addr_i ({rd_bank_q, rd_addr_q}),
    .rd_data_o (rd_data)
  );

  assign en_out  = en_out_q;
  assign cnt_out = cnt_out_q;
  assign yout_re = rd_data[2*width-1:width];
  assign yout_im = rd_data[width-1:0];
  assign ovf     = ovf_q;

endmodule
